// File: rtl/ncpu32k_wb_arbiter_pkg.sv
// Shared defaults and helpers for the writeback arbiter slice.
// Register/data widths mirror the system-wide regfile geometry.
package ncpu32k_wb_arbiter_pkg;

   localparam int NCPU_REG_AW  = 5;
   localparam int NCPU_DW      = 32;
   localparam int NCPU_WB_NREQ = 4;

   // Explicit wrap so non-power-of-2 requester counts rotate correctly.
   function automatic int rr_inc(input int idx, input int n);
      return (idx == n - 1) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/ncpu32k_rr_pick.sv
// Rotating priority encoder: first asserted request at or after ptr,
// reported as one-hot grant, binary index and a found flag.
module ncpu32k_rr_pick
   import ncpu32k_wb_arbiter_pkg::*;
#(
   parameter  int N  = 4,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] idx,
   output logic          found
);

   always_comb begin
      int j;
      grant = '0;
      idx   = '0;
      found = 1'b0;
      j     = int'(ptr);
      for (int k = 0; k < N; k++) begin
         if (!found && req[j]) begin
            grant[j] = 1'b1;
            idx      = IW'(j);
            found    = 1'b1;
         end
         j = rr_inc(j, N);
      end
   end

endmodule

// File: rtl/ncpu32k_wb_arbiter.sv
// Writeback arbiter: grants up to two non-r0 writes per cycle round-robin
// onto the two regfile write ports, registered with one cycle of latency.
module ncpu32k_wb_arbiter
   import ncpu32k_wb_arbiter_pkg::*;
#(
   parameter int NREQ = NCPU_WB_NREQ,
   parameter int AW   = NCPU_REG_AW,
   parameter int DW   = NCPU_DW
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*AW-1:0] req_waddr,
   input  logic [NREQ*DW-1:0] req_wdat,
   output logic              arf_1_we,
   output logic [AW-1:0]     arf_1_waddr,
   output logic [DW-1:0]     arf_1_wdat,
   output logic              arf_2_we,
   output logic [AW-1:0]     arf_2_waddr,
   output logic [DW-1:0]     arf_2_wdat,
   output logic              wb_stall
);

   localparam int IW = $clog2(NREQ);

   logic [NREQ-1:0] r0_hit;
   logic [NREQ-1:0] nz_req;
   logic [NREQ-1:0] g2_req;
   logic [NREQ-1:0] g1_oh;
   logic [NREQ-1:0] g2_oh;
   logic [IW-1:0]   g1_idx;
   logic [IW-1:0]   g2_idx;
   logic            g1_found;
   logic            g2_found;
   logic [AW-1:0]   g1_waddr;
   logic [DW-1:0]   g1_wdat;
   logic [AW-1:0]   g2_waddr;
   logic [DW-1:0]   g2_wdat;
   logic [IW-1:0]   rr_ptr;
   logic [IW-1:0]   rr_ptr_nxt;

   // r0 writes are acknowledged but never reach a port.
   always_comb begin
      r0_hit = '0;
      nz_req = '0;
      for (int i = 0; i < NREQ; i++) begin
         r0_hit[i] = req_valid[i] & (req_waddr[i*AW +: AW] == '0);
         nz_req[i] = req_valid[i] & (req_waddr[i*AW +: AW] != '0);
      end
   end

   ncpu32k_rr_pick #(.N(NREQ)) u_pick_1 (
      .req   (nz_req),
      .ptr   (rr_ptr),
      .grant (g1_oh),
      .idx   (g1_idx),
      .found (g1_found)
   );

   always_comb begin
      g1_waddr = '0;
      g1_wdat  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (g1_oh[i]) begin
            g1_waddr = req_waddr[i*AW +: AW];
            g1_wdat  = req_wdat[i*DW +: DW];
         end
      end
   end

   // Second pick excludes G1 and anything targeting G1's register.
   always_comb begin
      g2_req = '0;
      for (int i = 0; i < NREQ; i++)
         g2_req[i] = nz_req[i] & ~g1_oh[i] & (req_waddr[i*AW +: AW] != g1_waddr);
   end

   ncpu32k_rr_pick #(.N(NREQ)) u_pick_2 (
      .req   (g2_req),
      .ptr   (rr_ptr),
      .grant (g2_oh),
      .idx   (g2_idx),
      .found (g2_found)
   );

   always_comb begin
      g2_waddr = '0;
      g2_wdat  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (g2_oh[i]) begin
            g2_waddr = req_waddr[i*AW +: AW];
            g2_wdat  = req_wdat[i*DW +: DW];
         end
      end
   end

   assign req_ready = rst_n ? (r0_hit | g1_oh | g2_oh) : '0;
   assign wb_stall  = rst_n & (|(req_valid & ~req_ready));

   always_comb begin
      rr_ptr_nxt = rr_ptr;
      if (g2_found)
         rr_ptr_nxt = IW'(rr_inc(int'(g2_idx), NREQ));
      else if (g1_found)
         rr_ptr_nxt = IW'(rr_inc(int'(g1_idx), NREQ));
   end

   // Grant -> regfile write port stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         arf_1_we    <= 1'b0;
         arf_1_waddr <= '0;
         arf_1_wdat  <= '0;
         arf_2_we    <= 1'b0;
         arf_2_waddr <= '0;
         arf_2_wdat  <= '0;
         rr_ptr      <= '0;
      end else begin
         arf_1_we <= g1_found;
         arf_2_we <= g2_found;
         if (g1_found) begin
            arf_1_waddr <= g1_waddr;
            arf_1_wdat  <= g1_wdat;
         end
         if (g2_found) begin
            arf_2_waddr <= g2_waddr;
            arf_2_wdat  <= g2_wdat;
         end
         rr_ptr <= rr_ptr_nxt;
      end
   end

endmodule

// File: tb/tb_ncpu32k_wb_arbiter.sv
// Bench for ncpu32k_wb_arbiter: directed scenarios plus randomized traffic,
// each cycle compared against a rule-level model of grants and port writes.
module tb_ncpu32k_wb_arbiter;

   localparam int NREQ = 4;
   localparam int AW   = 5;
   localparam int DW   = 32;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*AW-1:0] req_waddr;
   logic [NREQ*DW-1:0] req_wdat;
   logic              arf_1_we;
   logic [AW-1:0]     arf_1_waddr;
   logic [DW-1:0]     arf_1_wdat;
   logic              arf_2_we;
   logic [AW-1:0]     arf_2_waddr;
   logic [DW-1:0]     arf_2_wdat;
   logic              wb_stall;

   always #5 clk = ~clk;

   ncpu32k_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_waddr   (req_waddr),
      .req_wdat    (req_wdat),
      .arf_1_we    (arf_1_we),
      .arf_1_waddr (arf_1_waddr),
      .arf_1_wdat  (arf_1_wdat),
      .arf_2_we    (arf_2_we),
      .arf_2_waddr (arf_2_waddr),
      .arf_2_wdat  (arf_2_wdat),
      .wb_stall    (wb_stall)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   // Requester-side state and model of the regfile ports
   logic [NREQ-1:0] v;
   logic [AW-1:0]   a [NREQ];
   logic [DW-1:0]   d [NREQ];
   int              rr;
   logic            e1_we, e2_we;
   logic [AW-1:0]   e1_a, e2_a;
   logic [DW-1:0]   e1_d, e2_d;
   logic [NREQ-1:0] rdy;

   task automatic drive();
      for (int i = 0; i < NREQ; i++) begin
         req_valid[i]            = v[i];
         req_waddr[i*AW +: AW]   = a[i];
         req_wdat[i*DW +: DW]    = d[i];
      end
   endtask

   task automatic model_reset();
      v = '0; rr = 0;
      e1_we = 1'b0; e2_we = 1'b0;
      e1_a = '0; e2_a = '0; e1_d = '0; e2_d = '0;
   endtask

   task automatic check_ports();
      chk("arf_1_we",    arf_1_we,    e1_we);
      chk("arf_1_waddr", arf_1_waddr, e1_a);
      chk("arf_1_wdat",  arf_1_wdat,  e1_d);
      chk("arf_2_we",    arf_2_we,    e2_we);
      chk("arf_2_waddr", arf_2_waddr, e2_a);
      chk("arf_2_wdat",  arf_2_wdat,  e2_d);
   endtask

   // One cycle: drive at negedge, check ready, clock, check ports.
   task automatic step(output logic [NREQ-1:0] got_rdy);
      logic [NREQ-1:0] m_rdy;
      int g1, g2, j;
      drive();
      #1;
      m_rdy = '0; g1 = -1; g2 = -1;
      for (int i = 0; i < NREQ; i++)
         if (v[i] && a[i] == '0) m_rdy[i] = 1'b1;
      for (int k = 0; k < NREQ; k++) begin
         j = (rr + k) % NREQ;
         if (v[j] && a[j] != '0) begin
            if (g1 < 0) g1 = j;
            else if (g2 < 0 && a[j] != a[g1]) g2 = j;
         end
      end
      if (g1 >= 0) m_rdy[g1] = 1'b1;
      if (g2 >= 0) m_rdy[g2] = 1'b1;
      chk("req_ready", req_ready, m_rdy);
      chk("wb_stall",  wb_stall,  |(v & ~m_rdy));
      e1_we = (g1 >= 0);
      e2_we = (g2 >= 0);
      if (g1 >= 0) begin e1_a = a[g1]; e1_d = d[g1]; end
      if (g2 >= 0) begin e2_a = a[g2]; e2_d = d[g2]; end
      if (g2 >= 0)      rr = (g2 + 1) % NREQ;
      else if (g1 >= 0) rr = (g1 + 1) % NREQ;
      v = v & ~m_rdy;
      got_rdy = m_rdy;
      @(posedge clk);
      #1;
      check_ports();
      @(negedge clk);
   endtask

   initial begin
      model_reset();
      for (int i = 0; i < NREQ; i++) begin
         a[i] = AW'(i + 1);
         d[i] = 32'h100 + i;
      end
      v = '1;
      drive();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", req_ready, '0);
      chk("rst_stall", wb_stall, 1'b0);
      chk("rst_we1", arf_1_we, 1'b0);
      chk("rst_we2", arf_2_we, 1'b0);
      chk("rst_waddr1", arf_1_waddr, '0);
      chk("rst_wdat2", arf_2_wdat, '0);
      @(negedge clk);
      rst_n = 1'b1;

      // All valid, distinct addresses: pairs rotate and wrap.
      for (int c = 0; c < 4; c++) begin
         for (int i = 0; i < NREQ; i++) begin
            v[i] = 1'b1; a[i] = AW'(i + 1); d[i] = $urandom;
         end
         step(rdy);
         chk("rr_pair", rdy, (c % 2 == 0) ? 4'b0011 : 4'b1100);
      end

      // Same-address deferral with rr at 0.
      v = '0;
      v[0] = 1'b1; a[0] = 7; d[0] = 32'hA0A0A0A0;
      v[1] = 1'b1; a[1] = 7; d[1] = 32'hB1B1B1B1;
      step(rdy);
      chk("same_addr", rdy, 4'b0001);
      step(rdy);
      chk("same_addr_next", rdy, 4'b0010);
      chk("same_addr_wdat", arf_1_wdat, 32'hB1B1B1B1);

      // Single write.
      v[2] = 1'b1; a[2] = 5; d[2] = 32'hDEADBEEF;
      step(rdy);
      chk("single_ready", rdy, 4'b0100);
      chk("single_wdat", arf_1_wdat, 32'hDEADBEEF);
      chk("single_we2", arf_2_we, 1'b0);

      // r0 absorb.
      v[0] = 1'b1; a[0] = 0; d[0] = $urandom;
      v[1] = 1'b1; a[1] = 3; d[1] = $urandom;
      step(rdy);
      chk("r0_ready", rdy, 4'b0011);
      chk("r0_waddr1", arf_1_waddr, 5'd3);
      chk("r0_we2", arf_2_we, 1'b0);

      // Randomized traffic with narrow address range for conflicts and r0.
      repeat (400) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!v[i] && $urandom_range(0, 9) < 6) begin
               v[i] = 1'b1;
               a[i] = AW'($urandom_range(0, 7));
               d[i] = $urandom;
            end
         end
         step(rdy);
      end

      // Asynchronous reset while writes are in flight.
      for (int i = 0; i < NREQ; i++) begin
         v[i] = 1'b1; a[i] = AW'(i + 9); d[i] = $urandom;
      end
      drive();
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_we1", arf_1_we, 1'b0);
      chk("async_we2", arf_2_we, 1'b0);
      chk("async_ready", req_ready, '0);
      model_reset();
      drive();
      @(posedge clk);
      #1;
      check_ports();
      @(negedge clk);
      rst_n = 1'b1;

      repeat (60) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!v[i] && $urandom_range(0, 9) < 7) begin
               v[i] = 1'b1;
               a[i] = AW'($urandom_range(0, 5));
               d[i] = $urandom;
            end
         end
         step(rdy);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
